// File: rtl/rr_arbiter16.sv
// Sixteen-requester round-robin arbiter with registered index and one-hot grant.
// Optional hold timeout compiled in with `define ARB_TIMEOUT_EN (limit = MAX_HOLD).
module rr_arbiter16 #(
  parameter int MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] req,
  output logic        gnt_valid,
  output logic [3:0]  gnt_idx,
  output logic [15:0] gnt,
  output logic        timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter16: MAX_HOLD must be within 2..255");
  end

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t      state, state_next;
  logic [3:0]  ptr, ptr_next;
  logic [3:0]  idx_next;
  logic [15:0] gnt_next;
  logic        timeout_next;
  logic [3:0]  sel;
  logic [3:0]  cand;
  logic        found;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt, hold_cnt_next;
`endif

  // Rotating priority scan: first set request at ptr, ptr+1, ... wrapping 15 -> 0.
  always_comb begin
    sel   = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cand = ptr + 4'(i);
      if (!found && req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    idx_next     = gnt_idx;
    timeout_next = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_next = hold_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (en && found) begin
          idx_next   = sel;
          state_next = GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_next = 8'd0;
`endif
        end
      end
      GRANT: begin
        if (!req[gnt_idx]) begin
          // A release on the same edge as expiry is a normal release.
          state_next = IDLE;
          ptr_next   = gnt_idx + 4'd1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt == HOLD_LAST) begin
          state_next   = IDLE;
          ptr_next     = gnt_idx + 4'd1;
          timeout_next = 1'b1;
        end else begin
          hold_cnt_next = hold_cnt + 8'd1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
    gnt_next = (state_next == GRANT) ? (16'd1 << idx_next) : 16'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 4'd0;
      gnt_idx <= 4'd0;
      gnt     <= 16'd0;
      timeout <= 1'b0;
    end else begin
      state   <= state_next;
      ptr     <= ptr_next;
      gnt_idx <= idx_next;
      gnt     <= gnt_next;
      timeout <= timeout_next;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) hold_cnt <= 8'd0;
    else     hold_cnt <= hold_cnt_next;
  end
`endif

  assign gnt_valid = (state == GRANT);

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed self-checking bench for rr_arbiter16 (MAX_HOLD = 4).
// Timeout expectations follow whether ARB_TIMEOUT_EN is defined for the build.
module tb_rr_arbiter16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] req;
  logic        gnt_valid;
  logic [3:0]  gnt_idx;
  logic [15:0] gnt;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  rr_arbiter16 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .gnt       (gnt),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs for a given grant state; idx is checked only while granted.
  task automatic expect_out(input string tag, input logic v, input logic [3:0] idx,
                            input logic to);
    logic [15:0] onehot;
    onehot = v ? (16'd1 << idx) : 16'd0;
    check({tag, ".valid"}, {31'd0, gnt_valid}, {31'd0, v});
    check({tag, ".gnt"}, {16'd0, gnt}, {16'd0, onehot});
    check({tag, ".timeout"}, {31'd0, timeout}, {31'd0, to});
    if (v) check({tag, ".idx"}, {28'd0, gnt_idx}, {28'd0, idx});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b1;
    req = 16'h0000;

    // Reset and quiet idle.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      expect_out("idle", 1'b0, 4'd0, 1'b0);
      check("idle.idx", {28'd0, gnt_idx}, 32'd0);
      step();
    end

    // First grant from ptr=0 goes to 4, then 7 after one IDLE cycle.
    req = 16'h0090;
    step(); expect_out("g4", 1'b1, 4'd4, 1'b0);
    step(); expect_out("g4_hold", 1'b1, 4'd4, 1'b0);
    req = 16'h0080;
    step(); expect_out("g4_rel", 1'b0, 4'd0, 1'b0);
    step(); expect_out("g7", 1'b1, 4'd7, 1'b0);
    req = 16'h0000;
    step(); expect_out("g7_rel", 1'b0, 4'd0, 1'b0);

    // Full sweep with all requesting: 0..15 then wrap to 0.
    do_reset();
    req = 16'hFFFF;
    for (int k = 0; k < 17; k++) begin
      step(); expect_out($sformatf("sweep%0d", k), 1'b1, 4'(k), 1'b0);
      req = 16'hFFFF & ~(16'd1 << (k % 16));
      step(); expect_out($sformatf("sweep%0d_rel", k), 1'b0, 4'd0, 1'b0);
      req = 16'hFFFF;
    end
    req = 16'h0000;
    step();

    // Enable gating.
    do_reset();
    en = 1'b0; req = 16'h0001;
    step(); expect_out("en0_a", 1'b0, 4'd0, 1'b0);
    step(); expect_out("en0_b", 1'b0, 4'd0, 1'b0);
    en = 1'b1;
    step(); expect_out("en1", 1'b1, 4'd0, 1'b0);
    en = 1'b0;
    step(); expect_out("en_drop_a", 1'b1, 4'd0, 1'b0);
    step(); expect_out("en_drop_b", 1'b1, 4'd0, 1'b0);
    req = 16'h0000;
    step(); expect_out("en_rel", 1'b0, 4'd0, 1'b0);
    en = 1'b1;

    // Reset mid-grant to client 9 restores ptr=0 (ptr was 1 here).
    req = 16'h0200;
    step(); expect_out("g9", 1'b1, 4'd9, 1'b0);
    rst = 1'b1;
    step(); expect_out("rst_mid", 1'b0, 4'd0, 1'b0);
    check("rst_mid.idx", {28'd0, gnt_idx}, 32'd0);
    rst = 1'b0; req = 16'h0201;
    step(); expect_out("post_rst", 1'b1, 4'd0, 1'b0);
    req = 16'h0000;
    step(); expect_out("post_rst_rel", 1'b0, 4'd0, 1'b0);

    // Hold limit behaviour with two persistent requesters.
    do_reset();
    req = 16'h0003;
    step(); expect_out("hold1", 1'b1, 4'd0, 1'b0);
`ifdef ARB_TIMEOUT_EN
    step(); expect_out("hold2", 1'b1, 4'd0, 1'b0);
    step(); expect_out("hold3", 1'b1, 4'd0, 1'b0);
    step(); expect_out("hold4", 1'b1, 4'd0, 1'b0);
    step(); expect_out("to_pulse", 1'b0, 4'd0, 1'b1);
    step(); expect_out("to_next", 1'b1, 4'd1, 1'b0);
    req = 16'h0001;
    step(); expect_out("to_rel", 1'b0, 4'd0, 1'b0);
    step(); expect_out("to_back0", 1'b1, 4'd0, 1'b0);
`else
    for (int i = 0; i < 12; i++) begin
      step(); expect_out($sformatf("nohold%0d", i), 1'b1, 4'd0, 1'b0);
    end
    req = 16'h0002;
    step(); expect_out("nohold_rel", 1'b0, 4'd0, 1'b0);
    step(); expect_out("nohold_g1", 1'b1, 4'd1, 1'b0);
`endif
    req = 16'h0000;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
